riscv_mem_arbiter: RTL
======================

// Module: riscv_mem_arbiter
// PURPOSE
//  Shares one unified memory port between the pipelined core's fetch requester (IF) and data requester (DM).
//  Each requester is granted in turn. Address, write data and byte enables are latched into one outstanding transaction.
//  The transaction is held on the memory port until the memory acknowledges it, and the completion is routed back to its owner.
//  Sits between riscv_pipelined_cpu's o_PCF/i_instrF and o_alu_resultM/i_mem_readdataM paths and a single-port memory with variable latency.
// PARAMETERS
//  TIMEOUT_CYCLES  default 255  max BUSY cycles without i_mem_ack before abort; range 1..255, 8-bit counter
// PORTS
//  i_clk          in   1      clock; all state changes on the rising edge
//  i_rstn         in   1      asynchronous, active-low reset
//  i_if_req       in   1      fetch request; held high until o_if_gnt
//  i_if_addr      in   XLEN   fetch address
//  o_if_gnt       out  1      fetch request accepted (1-cycle pulse)
//  o_if_rvalid    out  1      fetch complete; o_if_rdata valid (1-cycle pulse)
//  o_if_rdata     out  XLEN   fetched instruction
//  i_dm_req       in   1      data request; held high until o_dm_gnt
//  i_dm_we        in   1      1 = store, 0 = load
//  i_dm_be        in   4      byte enables
//  i_dm_addr      in   XLEN   data address
//  i_dm_wdata     in   XLEN   store data
//  o_dm_gnt       out  1      data request accepted (1-cycle pulse)
//  o_dm_rvalid    out  1      data transaction complete (1-cycle pulse)
//  o_dm_rdata     out  XLEN   load data; 0 for stores
//  o_mem_req      out  1      memory transaction active
//  o_mem_we       out  1      memory write enable
//  o_mem_be       out  4      memory byte enables; 4'hF for fetches
//  o_mem_addr     out  XLEN   memory address
//  o_mem_wdata    out  XLEN   memory write data
//  i_mem_ack      in   1      memory done; i_mem_rdata valid in the same cycle
//  i_mem_rdata    in   XLEN   memory read data
//  o_err_timeout  out  1      sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  - FSM states: IDLE, BUSY_IF, BUSY_DM. Reset: IDLE; every registered output 0; timeout counter 0.
//  - IDLE:
//    - Grant is combinational: o_x_gnt = IDLE & i_x_req & selected.
//    - On grant, latch addr/we/be/wdata into mem regs and go to BUSY_x.
//    - IF grants force we=0 and be=4'hF.
//  - BUSY_x:
//    - o_mem_req=1 with the latched fields, held stable until i_mem_ack.
//    - No grants are given while in BUSY_x.
//    - i_req changes are ignored while in BUSY_x.
//  - Completion, on the i_mem_ack cycle:
//    - Next cycle: o_x_rvalid=1 for one cycle.
//    - Next cycle: o_x_rdata = i_mem_rdata registered (DM store: 0).
//    - Next cycle: o_mem_req=0 and state = IDLE.
//  - Minimum latency: req in cycle 0 -> gnt cycle 0 -> o_mem_req cycle 1 -> ack cycle 1 -> rvalid cycle 2.
//  - Back-to-back: a new grant is possible in the rvalid cycle (state is IDLE).
//  - Arbitration: both requests in IDLE -> DM wins (fixed priority) unless MEM_ARB_RR_EN is defined.
//  - Timeout:
//    - Counter clears on grant and increments each BUSY cycle without ack.
//    - When the counter reaches TIMEOUT_CYCLES: abort. Next cycle: o_mem_req=0, o_x_rvalid=1, o_x_rdata=0, o_err_timeout=1 (sticky), state IDLE.
//    - Ack in the same cycle as the terminal count: ack wins; normal completion, no error.
//  - Reset mid-transaction: immediate return to IDLE; the outstanding transaction is dropped; no rvalid.
//  - o_x_rdata holds its value between rvalid pulses.
// CONFIGURATION
//  MEM_ARB_RR_EN defined:
//    - Round-robin on contention; a 1-bit last_owner register (reset 0 = IF) records the last granted requester.
//    - The requester not granted last wins the tie.
//    - A lone request is always granted.
//  MEM_ARB_RR_EN undefined:
//    - Fixed priority DM > IF; no last_owner register.
// STRUCTURE
//  - XLEN comes from the shared ../common/riscv_configs.v.
//  - Add to riscv_configs.v: state encodings `MEM_ARB_IDLE=2'd0, `MEM_ARB_BUSY_IF=2'd1, `MEM_ARB_BUSY_DM=2'd2; `MEM_ARB_FETCH_BE=4'hF.
//  - One sub-module: riscv_mem_arb_timer.
//    - Contains the 8-bit counter with clear/enable inputs and a terminal-count output.
//    - Also uses i_clk/i_rstn.
//  - FSM, latches and response routing stay in the top module.
// TESTING
//  - Reset: i_rstn=0 mid-BUSY_DM with ack pending -> all outputs 0; state IDLE; no rvalid after release.
//  - Single fetch: i_if_req, addr 32'h100, ack 2 cycles after o_mem_req with rdata 32'h00500093 -> gnt@0, o_mem_be=F, o_mem_we=0, o_if_rvalid@4, o_if_rdata=32'h00500093.
//  - Store: i_dm_we=1, be=4'b0011, addr 32'h2000, wdata 32'hDEADBEEF -> o_mem_* match for every BUSY cycle; o_dm_rvalid with rdata 0.
//  - Contention:
//    - Both reqs held for 4 transactions, ack after 1 cycle.
//    - Without MEM_ARB_RR_EN: grants DM,DM,... while i_dm_req stays high.
//    - With MEM_ARB_RR_EN: grants alternate DM,IF,DM,IF (last_owner=IF at reset).
//  - Timeout:
//    - TIMEOUT_CYCLES=4, never ack -> o_mem_req drops after 4 BUSY cycles; rvalid with rdata 0; o_err_timeout=1 held through later good transactions.
//    - Ack on the terminal cycle -> no error.
//  - Back-to-back: DM req held high through completion -> second o_dm_gnt in the same cycle as the first o_dm_rvalid.

Source files
------------

// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Holds XLEN, the arbiter state encoding and the fetch byte-enable mask.
package riscv_mem_arbiter_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] MEM_ARB_FETCH_BE = 4'hF;

  typedef enum logic [1:0] {
    MEM_ARB_IDLE    = 2'd0,
    MEM_ARB_BUSY_IF = 2'd1,
    MEM_ARB_BUSY_DM = 2'd2
  } arbState_t;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Request, response and memory-port bundle of the memory arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface riscv_mem_arbiter_if;
  import riscv_mem_arbiter_pkg::*;

  logic            i_if_req;
  logic [XLEN-1:0] i_if_addr;
  logic            o_if_gnt;
  logic            o_if_rvalid;
  logic [XLEN-1:0] o_if_rdata;

  logic            i_dm_req;
  logic            i_dm_we;
  logic [3:0]      i_dm_be;
  logic [XLEN-1:0] i_dm_addr;
  logic [XLEN-1:0] i_dm_wdata;
  logic            o_dm_gnt;
  logic            o_dm_rvalid;
  logic [XLEN-1:0] o_dm_rdata;

  logic            o_mem_req;
  logic            o_mem_we;
  logic [3:0]      o_mem_be;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic            i_mem_ack;
  logic [XLEN-1:0] i_mem_rdata;

  logic            o_err_timeout;

  modport slave (
    input  i_if_req, i_if_addr,
    input  i_dm_req, i_dm_we, i_dm_be,
    input  i_dm_addr, i_dm_wdata,
    input  i_mem_ack, i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    output o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    output o_mem_req, o_mem_we, o_mem_be,
    output o_mem_addr, o_mem_wdata,
    output o_err_timeout
  );

  modport master (
    output i_if_req, i_if_addr,
    output i_dm_req, i_dm_we, i_dm_be,
    output i_dm_addr, i_dm_wdata,
    output i_mem_ack, i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    input  o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    input  o_mem_req, o_mem_we, o_mem_be,
    input  o_mem_addr, o_mem_wdata,
    input  o_err_timeout
  );

endinterface

// File: rtl/riscv_mem_arbiter_timer.sv
// 8-bit BUSY-cycle counter for the arbiter's transaction timeout.
// tc flags the cycle in which the count would reach LIMIT.
module riscv_mem_arb_timer #(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] Last = 8'(LIMIT - 1);

  logic [7:0] cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tc = en && (cnt == Last);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between fetch (IF) and data (DM) requesters.
// Define MEM_ARB_RR_EN for round-robin on contention; default DM > IF.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  riscv_mem_arbiter_if.slave   bus
);

  arbState_t state, nextState;

  logic idle, busyIf, busyDm, busy;
  logic ack, abort, done;
  logic dmPrio, selDm;
  logic ifGnt, dmGnt, memReq;

  logic            memWe;
  logic [3:0]      memBe;
  logic [XLEN-1:0] memAddr, memWdata;
  logic            ifRvalid, dmRvalid;
  logic [XLEN-1:0] ifRdata, dmRdata;
  logic            errTimeout;

  assign idle   = state == MEM_ARB_IDLE;
  assign busyIf = state == MEM_ARB_BUSY_IF;
  assign busyDm = state == MEM_ARB_BUSY_DM;
  assign busy   = busyIf | busyDm;
  assign ack    = bus.i_mem_ack;
  assign done   = ack | abort;

`ifdef MEM_ARB_RR_EN
  logic lastOwner;

  // 0 = IF, 1 = DM; the other side wins the next tie
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lastOwner <= 1'b0;
    end else if (dmGnt) begin
      lastOwner <= 1'b1;
    end else if (ifGnt) begin
      lastOwner <= 1'b0;
    end
  end

  assign dmPrio = ~lastOwner;
`else
  assign dmPrio = 1'b1;
`endif

  assign selDm = bus.i_dm_req &
                 (~bus.i_if_req | dmPrio);

  riscv_mem_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) uTimer (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .clr    (ifGnt | dmGnt),
    .en     (busy & ~ack),
    .tc     (abort)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= MEM_ARB_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      MEM_ARB_IDLE: begin
        unique case (1'b1)
          dmGnt:   nextState = MEM_ARB_BUSY_DM;
          ifGnt:   nextState = MEM_ARB_BUSY_IF;
          default: nextState = MEM_ARB_IDLE;
        endcase
      end
      MEM_ARB_BUSY_IF,
      MEM_ARB_BUSY_DM: begin
        if (done) begin
          nextState = MEM_ARB_IDLE;
        end
      end
      default: nextState = MEM_ARB_IDLE;
    endcase
  end

  always_comb begin
    dmGnt  = idle & selDm;
    ifGnt  = idle & bus.i_if_req & ~selDm;
    memReq = busy;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      memWe      <= 1'b0;
      memBe      <= '0;
      memAddr    <= '0;
      memWdata   <= '0;
      ifRvalid   <= 1'b0;
      dmRvalid   <= 1'b0;
      ifRdata    <= '0;
      dmRdata    <= '0;
      errTimeout <= 1'b0;
    end else begin
      if (dmGnt) begin
        memWe    <= bus.i_dm_we;
        memBe    <= bus.i_dm_be;
        memAddr  <= bus.i_dm_addr;
        memWdata <= bus.i_dm_wdata;
      end else if (ifGnt) begin
        memWe    <= 1'b0;
        memBe    <= MEM_ARB_FETCH_BE;
        memAddr  <= bus.i_if_addr;
        memWdata <= '0;
      end
      ifRvalid <= busyIf & done;
      dmRvalid <= busyDm & done;
      if (busyIf & done) begin
        ifRdata <= ack ? bus.i_mem_rdata : '0;
      end
      // stores and aborted loads both return zero
      if (busyDm & done) begin
        dmRdata <= (ack & ~memWe) ?
                   bus.i_mem_rdata : '0;
      end
      if (abort) begin
        errTimeout <= 1'b1;
      end
    end
  end

  assign bus.o_if_gnt      = ifGnt;
  assign bus.o_dm_gnt      = dmGnt;
  assign bus.o_if_rvalid   = ifRvalid;
  assign bus.o_dm_rvalid   = dmRvalid;
  assign bus.o_if_rdata    = ifRdata;
  assign bus.o_dm_rdata    = dmRdata;
  assign bus.o_mem_req     = memReq;
  assign bus.o_mem_we      = memWe;
  assign bus.o_mem_be      = memBe;
  assign bus.o_mem_addr    = memAddr;
  assign bus.o_mem_wdata   = memWdata;
  assign bus.o_err_timeout = errTimeout;

endmodule
